// File: rtl/pe_load_seq.sv
// pe_load_seq: weight-load sequencer feeding the daisy-chained PE load bus.
// Tags each accepted weight with its PE id and issues it one cycle later.
module pe_load_seq #(
  parameter int NUM_PE        = 16,
  parameter int WGT_PER_PE    = 2,
  parameter int ID_WIDTH      = 6,
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_wgt_vld,
  input  logic [IN_DATA_WIDTH-1:0] i_wgt_data,
  output logic                     o_wgt_rdy,
  output logic                     o_load_vld,
  output logic [ID_WIDTH-1:0]      o_load_id,
  output logic [IN_DATA_WIDTH-1:0] o_load_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_start_err
);
  localparam int SW = (WGT_PER_PE > 1) ? $clog2(WGT_PER_PE) : 1;

  if (NUM_PE > 2**ID_WIDTH) begin : g_id_check
    $error("NUM_PE does not fit in ID_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                   r_state, w_next;
  logic [ID_WIDTH-1:0]      r_pe_cnt;
  logic [SW-1:0]            r_slot_cnt;
  logic                     r_load_vld, r_done, r_start_err;
  logic [ID_WIDTH-1:0]      r_load_id;
  logic [IN_DATA_WIDTH-1:0] r_load_data;
  logic                     w_acc, w_slot_last, w_pe_last, w_last;

  assign w_acc       = i_wgt_vld && o_wgt_rdy;
  assign w_slot_last = r_slot_cnt == SW'(WGT_PER_PE - 1);
  assign w_pe_last   = r_pe_cnt == ID_WIDTH'(NUM_PE - 1);
  assign w_last      = w_acc && w_slot_last && w_pe_last;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = (r_state == IDLE) ? (i_start ? LOAD : IDLE) :
             (r_state == LOAD) ? (w_last ? DONE : LOAD) : IDLE;
  end

  always_comb begin
    o_wgt_rdy = r_state == LOAD;
    o_busy    = r_state != IDLE;
  end

  // pe_cnt saturates on the final beat so it never leaves 0..NUM_PE-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pe_cnt    <= '0;
      r_slot_cnt  <= '0;
      r_load_vld  <= 1'b0;
      r_load_id   <= '0;
      r_load_data <= '0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_load_vld  <= w_acc;
      r_done      <= w_last;
      r_start_err <= i_start && r_state != IDLE;
      if (r_state == IDLE && i_start) begin
        r_pe_cnt   <= '0;
        r_slot_cnt <= '0;
      end else if (w_acc) begin
        r_slot_cnt <= w_slot_last ? '0 : r_slot_cnt + 1'b1;
        if (w_slot_last && !w_pe_last) r_pe_cnt <= r_pe_cnt + 1'b1;
      end
      if (w_acc) begin
        r_load_id   <= r_pe_cnt;
        r_load_data <= i_wgt_data;
      end
    end
  end

  assign o_load_vld  = r_load_vld;
  assign o_load_id   = r_load_id;
  assign o_load_data = r_load_data;
  assign o_done      = r_done;
  assign o_start_err = r_start_err;
endmodule

// File: tb/tb_pe_load_seq.sv
// tb_pe_load_seq: directed checks of pe_load_seq with 4-PE and 64-PE instances.
module tb_pe_load_seq;
  logic       clk = 1'b0;
  logic       rst_n, start, vld, sel;
  logic [7:0] data;
  logic       a_rdy, a_vld, a_busy, a_done, a_err;
  logic [5:0] a_id;
  logic [7:0] a_data;
  logic       b_rdy, b_vld, b_busy, b_done, b_err;
  logic [5:0] b_id;
  logic [7:0] b_data;
  logic       m_rdy, m_vld, m_busy, m_done, m_err;
  logic [5:0] m_id;
  logic [7:0] m_data;
  int         errors = 0;
  int         checks = 0;
  int         lid = 0;
  int         ldat = 0;

  always #5 clk = ~clk;

  pe_load_seq #(.NUM_PE(4), .WGT_PER_PE(2), .ID_WIDTH(6), .IN_DATA_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_wgt_vld(vld), .i_wgt_data(data),
    .o_wgt_rdy(a_rdy), .o_load_vld(a_vld), .o_load_id(a_id), .o_load_data(a_data),
    .o_busy(a_busy), .o_done(a_done), .o_start_err(a_err));

  pe_load_seq #(.NUM_PE(64), .WGT_PER_PE(2), .ID_WIDTH(6), .IN_DATA_WIDTH(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_wgt_vld(vld), .i_wgt_data(data),
    .o_wgt_rdy(b_rdy), .o_load_vld(b_vld), .o_load_id(b_id), .o_load_data(b_data),
    .o_busy(b_busy), .o_done(b_done), .o_start_err(b_err));

  assign m_rdy  = sel ? b_rdy  : a_rdy;
  assign m_vld  = sel ? b_vld  : a_vld;
  assign m_id   = sel ? b_id   : a_id;
  assign m_data = sel ? b_data : a_data;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_err  = sel ? b_err  : a_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start a sequence, stream beats with vld pattern, optionally pulse start mid-run / in DONE
  task automatic run(input int npe, input logic [31:0] pat, input int plen,
                     input int err_k, input bit err_done);
    int k = 0;
    bit acc, fin = 0, fired = 0, s;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(m_busy), 1);
    check("start_rdy", 32'(m_rdy), 1);
    check("start_err0", 32'(m_err), 0);
    for (int i = 0; i < 600 && !fin; i++) begin
      vld  = pat[i % plen];
      data = 8'(k + 1);
      start = (k == err_k) && !fired;
      if (start) fired = 1;
      s   = start;
      acc = vld && m_rdy;
      tick();
      start = 1'b0;
      check("start_err", 32'(m_err), 32'(s));
      check("load_vld", 32'(m_vld), 32'(acc));
      if (acc) begin
        lid  = k / 2;
        ldat = k + 1;
        k++;
      end
      check("load_id", 32'(m_id), 32'(lid));
      check("load_data", 32'(m_data), 32'(ldat));
      check("done", 32'(m_done), 32'(acc && k == 2 * npe));
      if (k == 2 * npe) fin = 1;
    end
    vld = 1'b0;
    if (!fin) check("timeout", 0, 1);
    check("done_busy", 32'(m_busy), 1);
    check("done_rdy", 32'(m_rdy), 0);
    start = err_done;
    tick();
    start = 1'b0;
    check("idle_busy", 32'(m_busy), 0);
    check("idle_done", 32'(m_done), 0);
    check("idle_vld", 32'(m_vld), 0);
    check("done_start_err", 32'(m_err), 32'(err_done));
    check("hold_id", 32'(m_id), 32'(lid));
    check("hold_data", 32'(m_data), 32'(ldat));
    if (err_done) begin
      tick();
      check("dropped_start", 32'(m_busy), 0);
      check("err_clear", 32'(m_err), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vld = 1'b0; data = 8'h00; sel = 1'b0;
    tick();
    tick();
    check("rst_vld", 32'(a_vld), 0);
    check("rst_id", 32'(a_id), 0);
    check("rst_data", 32'(a_data), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_err", 32'(a_err), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_rdy", 32'(a_rdy), 0);
    rst_n = 1'b1;
    vld = 1'b1; data = 8'hAA;
    tick();
    check("idle_rdy", 32'(a_rdy), 0);
    check("idle_vld_ignored", 32'(a_vld), 0);
    tick();
    check("idle_vld_ignored2", 32'(a_vld), 0);
    check("idle_data_held", 32'(a_data), 0);
    vld = 1'b0;
    run(4, 32'h1, 1, -1, 1'b0);
    run(4, 32'b01101, 5, -1, 1'b0);
    run(4, 32'h1, 1, 3, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = 8'(i + 1);
      tick();
    end
    check("pre_rst_id", 32'(a_id), 1);
    vld = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_vld", 32'(a_vld), 0);
    check("mid_rst_id", 32'(a_id), 0);
    check("mid_rst_data", 32'(a_data), 0);
    check("mid_rst_busy", 32'(a_busy), 0);
    check("mid_rst_rdy", 32'(a_rdy), 0);
    lid = 0;
    ldat = 0;
    run(4, 32'h1, 1, -1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sel = 1'b1;
    lid = 0;
    ldat = 0;
    run(64, 32'h1, 1, -1, 1'b0);
    check("final_id63", 32'(b_id), 63);
    run(64, 32'h1, 1, -1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
